// File: rtl/lsu_mem_adapter.sv
// rtl/lsu_mem_adapter.sv - byte/half/word load-store adapter onto a word-wide memory with ack timeout
//   core side  : req_i/we_i/size_i/unsigned_i/addr_i/wdata_i in; busy_o/done_o/err_o/rdata_o out
//   memory side: mem_rd_en_o/mem_wr_en_o/mem_addr_o/mem_data_o out; mem_data_i/mem_ack_i in
module lsu_mem_adapter #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    // cnt holds the number of cycles since the enable pulse; the wait gives up
    // once it reaches ACK_TIMEOUT-1 so done lands ACK_TIMEOUT cycles after the pulse.
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_d, done_d, err_d, rd_en_d, wr_en_d;
    logic [31:0]   rdata_d, mem_addr_d, mem_data_d;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Read-modify-write merge: only the addressed lane(s) take store data.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        case (size)
            2'b00:   m[{off, 3'b000} +: 8] = wd[7:0];
            2'b01:   m[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_o;
        mem_addr_d = mem_addr_o;
        mem_data_d = mem_data_o;

        case (state)
            IDLE: begin
                // mem_ack_i is deliberately not looked at here: stray/late acks vanish.
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    off_d   = addr_i[1:0];
                    wdata_d = wdata_i;
                    if (is_illegal(size_i, addr_i[1:0])) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        mem_addr_d = {addr_i[31:2], 2'b00};
                        cnt_d      = '0;
                        if (we_i && size_i == 2'b10) begin
                            mem_data_d = wdata_i;
                            state_d    = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                state_d = RD_WAIT;
                cnt_d   = cnt + 1'b1;
            end
            RD_WAIT: begin
                if (mem_ack_i) begin
                    if (we_q) begin
                        mem_data_d = merge(mem_data_i, size_q, off_q, wdata_q);
                        cnt_d      = '0;
                        state_d    = WR;
                    end else begin
                        rdata_d = extract(mem_data_i, size_q, off_q, uns_q);
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WR: begin
                state_d = WR_WAIT;
                cnt_d   = cnt + 1'b1;
            end
            WR_WAIT: begin
                if (mem_ack_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Enables are registered from the next state, so each is high only in RD / WR.
        busy_d  = (state_d != IDLE);
        rd_en_d = (state_d == RD);
        wr_en_d = (state_d == WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
            rdata_o     <= rdata_d;
            mem_rd_en_o <= rd_en_d;
            mem_wr_en_o <= wr_en_d;
            mem_addr_o  <= mem_addr_d;
            mem_data_o  <= mem_data_d;
        end
    end

endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store adapter between the core's data-access port and the word-wide Memory block.
- Converts byte, halfword and word loads and stores into single-cycle rd_en/wr_en pulses, then waits for ack.
- Sub-word stores are done as read-modify-write. Load data is extracted, then sign- or zero-extended.
- Flags misaligned or illegal accesses and missing acks as errors; the core sees a single done pulse per request.

Parameters:
- ACK_TIMEOUT, 16: max cycles to wait for mem_ack_i after an enable pulse before aborting with an error (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  access request; sampled only when busy_o=0
- we_i  in  1  1=store, 0=load
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- busy_o  out  1  request in flight
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o: misaligned, illegal size or timeout
- rdata_o  out  32  extended load result, valid from done_o onward
- mem_rd_en_o  out  1  read pulse to memory
- mem_wr_en_o  out  1  write pulse to memory
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_data_o  out  32  write word
- mem_data_i  in  32  read word from memory
- mem_ack_i  in  1  memory acknowledge; data valid with it

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all outputs 0 (busy_o, done_o, err_o, rdata_o, mem_* outputs).
  - Internal counter and latched request fields cleared.
- Register rules:
  - All outputs are registered.
  - Request fields (we, size, unsigned, addr, wdata) are latched at acceptance.
  - Acceptance: req_i=1 and state=IDLE at a clock edge.
- Alignment:
  - half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always illegal.
  - An illegal access does no memory cycle. Next cycle: done_o=1, err_o=1; rdata_o unchanged.
- Lane mapping: little-endian; byte k occupies bits [8k+7:8k]; half at offset 2 uses [31:16].
- FSM states: IDLE, RD, RD_WAIT, WR, WR_WAIT.
  - Load: IDLE->RD. In RD, mem_rd_en_o=1 for exactly one cycle, then RD_WAIT.
  - RD_WAIT on ack: extract the lane and extend (byte/half sign per unsigned_i) into rdata_o; done_o=1; go to IDLE.
  - Word store: IDLE->WR. In WR, mem_wr_en_o=1 for one cycle with mem_data_o=wdata, then WR_WAIT.
  - WR_WAIT on ack: done_o=1, err_o=0; go to IDLE.
  - Sub-word store: RD -> RD_WAIT, then on ack merge the low bytes of wdata into the selected lane(s) of mem_data_i, keeping other lanes. Then WR -> WR_WAIT -> done.
- Latency, with acceptance in cycle 0 and a memory that acks one cycle after the enable:
  - Word/sub-word load: rd_en in cycle 1, ack in cycle 2, done in cycle 3.
  - Word store: done in cycle 3.
  - Sub-word store: rd_en cycle 1, wr_en cycle 3, done cycle 5.
  - A new request may be accepted in the done cycle (state already IDLE); back-to-back accesses are possible.
- busy_o=1 in every non-IDLE state. mem_rd_en_o and mem_wr_en_o are never asserted together and never held for more than one cycle.
- Timeout:
  - The counter restarts on each enable pulse and counts the cycles spent in RD_WAIT or WR_WAIT.
  - At ACK_TIMEOUT without ack: done_o=1, err_o=1, go to IDLE.
  - A sub-word store that times out in its read phase issues no write.
- mem_ack_i while IDLE (late or stray ack) is ignored.
- rdata_o changes only on a successful load; stores and errors leave it unchanged.
- Reset mid-operation: everything aborts to the reset values immediately. Any memory ack already pending is ignored afterwards; no done_o is produced for the aborted request.
- req_i held high while busy_o=1 is not accepted until the done cycle.

Test Plan:
- Word write then read:
  - store word 0xDEADBEEF @0x10 -> one wr_en pulse with mem_addr_o=0x10, done 3 cycles after acceptance, err_o=0.
  - load word @0x10 -> rdata_o=0xDEADBEEF.
- Byte loads from word 0x80FF7F01 @0x20:
  - @0x20 signed -> 0x00000001.
  - @0x22 signed -> 0xFFFFFFFF.
  - @0x23 signed -> 0xFFFFFF80.
  - @0x23 unsigned -> 0x00000080.
  - half @0x22 signed -> 0xFFFF80FF.
- Sub-word store RMW:
  - word @0x30=0x11223344; store byte 0xAA @0x31 -> rd_en cycle 1, wr_en cycle 3 with mem_data_o=0x1122AA44, done cycle 5.
  - store half 0xBEEF @0x32 -> final word 0xBEEFAA44.
- Misaligned and illegal accesses:
  - load half @0x01, load word @0x06, size 11 @0x00 -> no enable pulses; done_o=err_o=1 in cycle 1; rdata_o unchanged.
- Timeout:
  - memory model never acks; load @0x40 -> done_o=err_o=1 exactly ACK_TIMEOUT cycles after the rd_en pulse.
  - a late ack injected afterwards is ignored.
- Reset mid-operation and back-to-back:
  - assert rst_n=0 during WR_WAIT -> all outputs 0 asynchronously, no done_o; a pending ack after release is ignored.
  - two loads issued back to back -> second accepted in the first's done cycle.
